// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared types and constants for the LED display controller
//
// Provides the mode encoding, the free-running counter width and the bit
// positions of the counter slices shown on the red LEDs, green LEDs and
// seven-segment digits.
package display_pkg;

  localparam int CNT_W     = 48;

  // Counter slices presented to the display
  localparam int RED_LSB   = 16;
  localparam int RED_W     = 16;
  localparam int GREEN_LSB = 15;
  localparam int GREEN_W   = 16;
  localparam int SEG_LSB   = 16;
  localparam int SEG_W     = 32;

  typedef enum logic [1:0] {
    MODE_RUN  = 2'd0,
    MODE_HOLD = 2'd1,
    MODE_STEP = 2'd2
  } mode_t;

  // Mode sequence on each mode-key press: RUN -> HOLD -> STEP -> RUN
  function automatic mode_t next_mode(input mode_t m);
    case (m)
      MODE_RUN:  return MODE_HOLD;
      MODE_HOLD: return MODE_STEP;
      default:   return MODE_RUN;
    endcase
  endfunction

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - pushbutton synchronizer, debouncer and press detector
//
// Synchronizes an asynchronous active-low key, accepts a level change only
// after it has been stable for DEBOUNCE_CYCLES samples, and emits a one-cycle
// pulse on each debounced press (1 -> 0). Releases produce no pulse.
//
// Ports:
//   clk_video  sampling clock
//   reset_n    asynchronous active-low reset
//   key_n      raw key, low = pressed, asynchronous to clk_video
//   pressed    registered one-cycle pulse per debounced press
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 740000
) (
  input  logic clk_video,
  input  logic reset_n,
  input  logic key_n,
  output logic pressed
);

  localparam int              DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic            r_sync1;
  logic            r_sync2;
  logic            r_state;
  logic            r_pressed;
  logic [DB_W-1:0] r_cnt;

  logic            w_differs;
  logic            w_accept;

  assign w_differs = (r_sync2 != r_state);
  assign w_accept  = w_differs && (r_cnt == DB_LAST);

  always_ff @(posedge clk_video or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_state   <= 1'b1;
      r_pressed <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_sync1   <= key_n;
      r_sync2   <= r_sync1;
      // Accepting a differing value of 0 means the debounced state was 1
      r_pressed <= w_accept && !r_sync2;
      if (w_accept) begin
        r_state <= r_sync2;
        r_cnt   <= '0;
      end else if (w_differs) begin
        r_cnt   <= r_cnt + 1'b1;
      end else begin
        r_cnt   <= '0;
      end
    end
  end

  assign pressed = r_pressed;

endmodule

// File: rtl/led_display_ctrl.sv
// rtl/led_display_ctrl.sv - frame-synchronous LED/segment display controller
//
// Debounces the mode and clear keys, runs the RUN/HOLD/STEP state machine
// over a 48-bit counter and snapshots the counter into the display outputs
// at each vsync leading edge so the LEDs never tear mid-frame.
//
// Ports:
//   clk_video   video clock, the only clock
//   reset_n     asynchronous active-low reset
//   key_mode_n  raw mode key, low = pressed, asynchronous
//   key_clr_n   raw clear key, low = pressed, asynchronous
//   vsync       vsync from display, polarity set by VSYNC_ACTIVE_LOW
//   red_leds    snapshot of counter[31:16]
//   green_leds  snapshot of counter[30:15]
//   segments    snapshot of counter[47:16]
//   mode        current mode (RUN=0, HOLD=1, STEP=2)
//   frame_upd   one-cycle pulse when the snapshot outputs load
module led_display_ctrl
  import display_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES  = 740000,
  parameter bit VSYNC_ACTIVE_LOW = 1'b1,
  parameter int STEP_SHIFT       = 16
) (
  input  logic                 clk_video,
  input  logic                 reset_n,
  input  logic                 key_mode_n,
  input  logic                 key_clr_n,
  input  logic                 vsync,
  output logic [RED_W-1:0]     red_leds,
  output logic [GREEN_W-1:0]   green_leds,
  output logic [SEG_W-1:0]     segments,
  output logic [1:0]           mode,
  output logic                 frame_upd
);

  localparam logic [CNT_W-1:0] STEP_INC = CNT_W'(1) << STEP_SHIFT;
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  logic [CNT_W-1:0]   r_cnt;
  mode_t              r_mode;
  logic               r_vsync_prev;
  logic [RED_W-1:0]   r_red;
  logic [GREEN_W-1:0] r_green;
  logic [SEG_W-1:0]   r_seg;
  logic               r_upd;

  logic               w_mode_press;
  logic               w_clr_press;
  logic               w_vsync_act;
  logic               w_vsync_prev_act;
  logic               w_frame_edge;
  logic [CNT_W-1:0]   w_cnt_nxt;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_db_mode (
    .clk_video (clk_video),
    .reset_n   (reset_n),
    .key_n     (key_mode_n),
    .pressed   (w_mode_press)
  );

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_db_clr (
    .clk_video (clk_video),
    .reset_n   (reset_n),
    .key_n     (key_clr_n),
    .pressed   (w_clr_press)
  );

  // Normalize vsync to active-high before edge detection
  assign w_vsync_act      = VSYNC_ACTIVE_LOW ? !vsync        : vsync;
  assign w_vsync_prev_act = VSYNC_ACTIVE_LOW ? !r_vsync_prev : r_vsync_prev;
  assign w_frame_edge     = w_vsync_act && !w_vsync_prev_act;

  // Clear wins over any increment; the mode in effect this cycle decides
  // the increment, so a mode press only changes behaviour from next cycle.
  assign w_cnt_nxt = w_clr_press                             ? '0 :
                     (r_mode == MODE_RUN)                    ? r_cnt + ONE :
                     ((r_mode == MODE_STEP) && w_frame_edge) ? r_cnt + STEP_INC :
                                                               r_cnt;

  always_ff @(posedge clk_video or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt        <= '0;
      r_vsync_prev <= VSYNC_ACTIVE_LOW;
    end else begin
      r_cnt        <= w_cnt_nxt;
      r_vsync_prev <= vsync;
    end
  end

  // Mode FSM; the unused encoding falls back to RUN on the next cycle
  always_ff @(posedge clk_video or negedge reset_n) begin
    if (!reset_n) begin
      r_mode <= MODE_RUN;
    end else begin
      case (r_mode)
        MODE_RUN, MODE_HOLD, MODE_STEP: begin
          if (w_mode_press) begin
            r_mode <= next_mode(r_mode);
          end
        end
        default: r_mode <= MODE_RUN;
      endcase
    end
  end

  // Snapshot takes the pre-update counter value at the frame edge. A frame
  // edge needs an inactive previous sample, so r_upd never fires twice in a row.
  always_ff @(posedge clk_video or negedge reset_n) begin
    if (!reset_n) begin
      r_red   <= '0;
      r_green <= '0;
      r_seg   <= '0;
      r_upd   <= 1'b0;
    end else begin
      r_upd <= w_frame_edge;
      if (w_frame_edge) begin
        r_red   <= r_cnt[RED_LSB +: RED_W];
        r_green <= r_cnt[GREEN_LSB +: GREEN_W];
        r_seg   <= r_cnt[SEG_LSB +: SEG_W];
      end
    end
  end

  assign red_leds   = r_red;
  assign green_leds = r_green;
  assign segments   = r_seg;
  assign mode       = r_mode;
  assign frame_upd  = r_upd;

endmodule

// File: tb/tb_led_display_ctrl.sv
// tb/tb_led_display_ctrl.sv - scoreboard bench for led_display_ctrl
module tb_led_display_ctrl;

  logic        clk_video = 1'b0;
  logic        reset_n   = 1'b0;
  logic        key_mode_n = 1'b1;
  logic        key_clr_n  = 1'b1;
  logic        vsync      = 1'b1;
  logic [15:0] red_leds;
  logic [15:0] green_leds;
  logic [31:0] segments;
  logic [1:0]  mode;
  logic        frame_upd;

  led_display_ctrl #(
    .DEBOUNCE_CYCLES (4),
    .VSYNC_ACTIVE_LOW(1'b1),
    .STEP_SHIFT      (16)
  ) dut (
    .clk_video (clk_video),
    .reset_n   (reset_n),
    .key_mode_n(key_mode_n),
    .key_clr_n (key_clr_n),
    .vsync     (vsync),
    .red_leds  (red_leds),
    .green_leds(green_leds),
    .segments  (segments),
    .mode      (mode),
    .frame_upd (frame_upd)
  );

  always #5 clk_video = ~clk_video;

  typedef struct {
    logic [15:0] red;
    logic [15:0] green;
    logic [31:0] seg;
    int          c;
  } snap_t;

  typedef struct {
    logic [1:0] m;
    int         c;
  } mode_ev_t;

  snap_t       snap_q[$];
  mode_ev_t    mode_q[$];
  int          n_checks = 0;
  int          n_err    = 0;
  int          cyc;
  int          k;
  logic [47:0] a_val;
  int          a_cyc;
  bit          a_run;
  logic [47:0] force_val;
  logic        prev_upd  = 1'b0;
  logic [1:0]  last_mode = 2'd0;

  always @(posedge clk_video or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk_video);
  endtask

  // Counter value right now, from the last known anchor (RUN: +1 per cycle)
  function automatic logic [47:0] cnt_now();
    return a_run ? a_val + 48'(cyc - a_cyc) : a_val;
  endfunction

  // One 100-cycle frame; vsync active low for 5 cycles. The edge lands on
  // the next posedge, so the snapshot shows 'pre' one cycle later.
  task automatic frame(input logic [47:0] pre);
    snap_q.push_back('{red: pre[31:16], green: pre[30:15], seg: pre[47:16], c: cyc + 1});
    vsync = 1'b0;
    step(5);
    vsync = 1'b1;
    step(95);
  endtask

  task automatic press(input bit is_mode, input int hold);
    if (is_mode) key_mode_n = 1'b0; else key_clr_n = 1'b0;
    step(hold);
    if (is_mode) key_mode_n = 1'b1; else key_clr_n = 1'b1;
  endtask

  // Overrides the counter's next value for one edge (RUN mode anchor follows)
  task automatic load_cnt(input logic [47:0] v);
    force_val = v;
    force dut.w_cnt_nxt = force_val;
    step(1);
    release dut.w_cnt_nxt;
    a_val = v;
    a_cyc = cyc;
  endtask

  // Snapshot monitor
  always @(negedge clk_video) begin
    if (reset_n && frame_upd) begin
      check("upd_not_consecutive", {63'd0, prev_upd}, 64'd0);
      if (snap_q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL unexpected_upd: frame_upd=1 at cycle %0d, required no pulse", cyc);
      end else begin
        snap_t e;
        e = snap_q.pop_front();
        check("snap_cycle", 64'(cyc), 64'(e.c));
        check("snap_red", {48'd0, red_leds}, {48'd0, e.red});
        check("snap_green", {48'd0, green_leds}, {48'd0, e.green});
        check("snap_seg", {32'd0, segments}, {32'd0, e.seg});
      end
    end
    prev_upd <= frame_upd;
  end

  // Mode-change monitor
  always @(negedge clk_video) begin
    if (!reset_n) begin
      last_mode <= 2'd0;
    end else if (mode != last_mode) begin
      if (mode_q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL unexpected_mode: mode %0d at cycle %0d, required %0d", mode, cyc, last_mode);
      end else begin
        mode_ev_t e;
        e = mode_q.pop_front();
        check("mode_value", {62'd0, mode}, {62'd0, e.m});
        check("mode_cycle", 64'(cyc), 64'(e.c));
      end
      last_mode <= mode;
    end
  end

  initial begin
    step(3);
    check("rst_red", {48'd0, red_leds}, 64'd0);
    check("rst_seg", {32'd0, segments}, 64'd0);
    check("rst_mode", {62'd0, mode}, 64'd0);
    check("rst_upd", {63'd0, frame_upd}, 64'd0);
    reset_n = 1'b1;
    a_val = '0; a_cyc = 0; a_run = 1'b1;

    // RUN from reset: outputs stay 0 until the first frame edge
    step(100);
    check("idle_red", {48'd0, red_leds}, 64'd0);
    check("idle_green", {48'd0, green_leds}, 64'd0);
    check("idle_seg", {32'd0, segments}, 64'd0);
    frame(cnt_now());
    frame(cnt_now());

    // Preload and snapshot: red 0x5678, green 0xACF1, seg 0x12345678
    load_cnt(48'h1234_5678_9ABC);
    frame(cnt_now());

    // Mode press -> HOLD, 7 cycles after the raw edge; counter freezes
    k = cyc;
    mode_q.push_back('{m: 2'd1, c: k + 7});
    press(1'b1, 10);
    a_val = a_val + 48'(k + 7 - a_cyc);
    a_run = 1'b0;
    for (int i = 0; i < 3; i++) frame(a_val);

    // 3-cycle glitch: no mode change
    press(1'b1, 3);
    step(20);

    // HOLD -> STEP: +0x10000 per frame edge
    k = cyc;
    mode_q.push_back('{m: 2'd2, c: k + 7});
    press(1'b1, 10);
    step(5);
    for (int i = 0; i < 3; i++) begin
      frame(a_val);
      a_val = a_val + 48'h1_0000;
    end

    // Clear coincident with a STEP frame edge
    fork
      press(1'b0, 10);
      begin
        step(6);
        frame(a_val);
      end
    join
    a_val = '0;
    frame(a_val);
    a_val = 48'h1_0000;
    frame(a_val);
    check("mode_step_after_clr", {62'd0, mode}, 64'd2);

    // Mode and clear together: STEP -> RUN and counter 0 at the same edge
    k = cyc;
    mode_q.push_back('{m: 2'd0, c: k + 7});
    fork
      press(1'b1, 10);
      press(1'b0, 10);
    join
    a_val = '0; a_cyc = k + 7; a_run = 1'b1;
    step(5);
    frame(cnt_now());

    // Wrap at 2^48
    load_cnt(48'hFFFF_FFFF_FFFF);
    frame(cnt_now());
    frame(cnt_now());

    // Reset mid-debounce with a frame edge pending
    load_cnt(48'hABCD_EF01_2345);
    frame(cnt_now());
    k = cyc;
    mode_q.push_back('{m: 2'd1, c: k + 7});
    press(1'b1, 10);
    step(10);
    key_mode_n = 1'b0;
    step(3);
    vsync = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_red", {48'd0, red_leds}, 64'd0);
    check("arst_green", {48'd0, green_leds}, 64'd0);
    check("arst_seg", {32'd0, segments}, 64'd0);
    check("arst_mode", {62'd0, mode}, 64'd0);
    check("arst_upd", {63'd0, frame_upd}, 64'd0);
    key_mode_n = 1'b1;
    vsync = 1'b1;
    step(3);
    reset_n = 1'b1;
    step(30);
    check("post_rst_mode", {62'd0, mode}, 64'd0);
    check("post_rst_seg", {32'd0, segments}, 64'd0);

    check("snap_q_empty", 64'(snap_q.size()), 64'd0);
    check("mode_q_empty", 64'(mode_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
